cdb_arbiter: RTL and testbench

Arbiter for the common data bus (CDB) feeding the ROB, reservation stations and RST. Functional units (integer ALU, load/store, multiplier, divider) each present one completed result; the block grants at most one per cycle, round-robin, and drives the registered CDB broadcast (tag, data, branch outcome). A flush input discards pending broadcasts on a mispredicted-branch retire.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rr_picker.sv | 33 +++
 rtl/cdb_arbiter.sv | 159 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB-side definitions: default tag/data widths, the CDB broadcast
// record and the instruction-type encoding used by ROB, RST and order queue.
package rob_pkg;

  localparam int TAG_W_DEF    = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    INST_RD_VALID = 2'b00,
    INST_BRANCH   = 2'b01,
    INST_STORE    = 2'b10
  } inst_type_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
    logic                  branch;
    logic                  taken;
  } cdb_rec_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first set bit of req at or after start,
// wrapping to 0. Purely combinational; shared with the issue schedulers.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest valid bit wins.
  always_comb begin
    int p;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int o = N - 1; o >= 0; o--) begin
      p = int'(start) + o;
      if (p >= N) p = p - N;
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = IDX_W'(p);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one completed functional-unit result per cycle in
// round-robin order and registers it onto the common data bus.
// Optional starvation override enabled by defining CDB_ARB_STARVE_EN.
module cdb_arbiter
  import rob_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int TAG_W        = TAG_W_DEF,
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int STARVE_LIMIT = 8,
  localparam int SRC_W        = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        Req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  Req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] Req_data,
  input  logic [NUM_REQ-1:0]        Req_branch,
  input  logic [NUM_REQ-1:0]        Req_branch_taken,
  output logic [NUM_REQ-1:0]        Req_ready,
  input  logic                      Flush,
  output logic                      Cdb_valid,
  output logic [TAG_W-1:0]          Cdb_rd_tag,
  output logic [DATA_W-1:0]         Cdb_data,
  output logic                      Cdb_branch,
  output logic                      Cdb_branch_taken,
  output logic [SRC_W-1:0]          Cdb_src
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("cdb_arbiter: STARVE_LIMIT must be 1..15");
  end

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [SRC_W-1:0]   rr_idx;
  logic               rr_any;
  logic [SRC_W-1:0]   win_idx;
  logic               win_any;
  logic               xfer;

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic               cdb_br_q, cdb_br_d;
  logic               cdb_tk_q, cdb_tk_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  rr_picker #(.N(NUM_REQ), .IDX_W(SRC_W)) u_pick (
    .req   (Req_valid),
    .start (rr_ptr_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef CDB_ARB_STARVE_EN
  logic [NUM_REQ-1:0][STARVE_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]                   starved;
  logic [SRC_W-1:0]                     st_idx;
  logic                                 st_any;

  // Lowest-index starved requester. A counter can overshoot the limit while
  // another starved requester is served, so it still counts as starved.
  always_comb begin
    starved = '0;
    st_idx  = '0;
    st_any  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      starved[i] = Req_valid[i] &&
                   (wait_cnt_q[i] >= STARVE_CNT_W'(STARVE_LIMIT));
      if (starved[i]) begin
        st_idx = SRC_W'(i);
        st_any = 1'b1;
      end
    end
  end

  // Saturating wait counters: count cycles spent valid but not granted.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Flush || !Req_valid[i] || Req_ready[i])
        wait_cnt_d[i] = '0;
      else if (wait_cnt_q[i] != {STARVE_CNT_W{1'b1}})
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
    end
  end

  // Wait counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Winner selection and one-hot grant; Flush and reset suppress everything.
  always_comb begin
    win_idx = rr_idx;
    win_any = rr_any;
`ifdef CDB_ARB_STARVE_EN
    if (st_any) begin
      win_idx = st_idx;
      win_any = 1'b1;
    end
`endif
    Req_ready = '0;
    if (win_any && reset && !Flush) Req_ready[win_idx] = 1'b1;
    xfer = |(Req_valid & Req_ready);
  end

  // Pointer advance and CDB capture; fields hold when nothing transfers.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = xfer;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_br_d    = cdb_br_q;
    cdb_tk_d    = cdb_tk_q;
    cdb_src_d   = cdb_src_q;
    if (xfer) begin
      rr_ptr_d   = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      cdb_tag_d  = Req_tag[win_idx*TAG_W +: TAG_W];
      cdb_data_d = Req_data[win_idx*DATA_W +: DATA_W];
      cdb_br_d   = Req_branch[win_idx];
      cdb_tk_d   = Req_branch_taken[win_idx];
      cdb_src_d  = win_idx;
    end
  end

  // Pointer and broadcast registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_br_q    <= 1'b0;
      cdb_tk_q    <= 1'b0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_br_q    <= cdb_br_d;
      cdb_tk_q    <= cdb_tk_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign Cdb_valid        = cdb_valid_q;
  assign Cdb_rd_tag       = cdb_tag_q;
  assign Cdb_data         = cdb_data_q;
  assign Cdb_branch       = cdb_br_q;
  assign Cdb_branch_taken = cdb_tk_q;
  assign Cdb_src          = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (4 requesters, 5-bit tags, 32-bit data).
module tb_cdb_arbiter;

`ifdef CDB_ARB_STARVE_EN
  localparam int LIMIT = 2;
`else
  localparam int LIMIT = 8;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  req_br, req_tk;
  logic [3:0]  req_ready;
  logic        flush;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_br, cdb_tk;
  logic [1:0]  cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .Req_valid(req_valid), .Req_tag(req_tag), .Req_data(req_data),
    .Req_branch(req_br), .Req_branch_taken(req_tk), .Req_ready(req_ready),
    .Flush(flush),
    .Cdb_valid(cdb_valid), .Cdb_rd_tag(cdb_tag), .Cdb_data(cdb_data),
    .Cdb_branch(cdb_br), .Cdb_branch_taken(cdb_tk), .Cdb_src(cdb_src)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] t, input logic [31:0] d,
                         input logic b, input logic k);
    req_tag[i*5 +: 5]   = t;
    req_data[i*32 +: 32] = d;
    req_br[i] = b;
    req_tk[i] = k;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    req_valid = 4'b0001; req_tag = '0; req_data = '0; req_br = '0; req_tk = '0;
    set_req(0, 5'd3, 32'h1234_5678, 1'b0, 1'b0);
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || cdb_tag !== 5'd0 || cdb_src !== 2'd0 || cdb_br !== 1'b0 || cdb_tk !== 1'b0)
      begin errors++; $display("FAIL rst_outputs got v=%b d=%h t=%0d s=%0d want all zero", cdb_valid, cdb_data, cdb_tag, cdb_src); end
    cyc(); reset = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_release_ready got %b want 0001", req_ready); end
    cyc();
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h1234_5678) begin errors++; $display("FAIL rst_pre_bcast got v=%b d=%h want 1 12345678", cdb_valid, cdb_data); end
    #2 reset = 1'b0; #1;
    checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || cdb_tag !== 5'd0) begin errors++; $display("FAIL rst_async got v=%b d=%h want 0 0", cdb_valid, cdb_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_async_ready got %b want 0000", req_ready); end
    req_valid = 4'b0000;
    cyc(); reset = 1'b1; #1;
  endtask

  // rr_ptr 0 after reset -> ends at 3.
  task automatic test_single();
    set_req(2, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd7 || cdb_data !== 32'hDEAD_BEEF || cdb_src !== 2'd2)
      begin errors++; $display("FAIL single_bcast got v=%b t=%0d d=%h s=%0d want 1 7 deadbeef 2", cdb_valid, cdb_tag, cdb_data, cdb_src); end
  endtask

  // rr_ptr 3 -> grant 0 -> pointer 1 (observed via 0/1 contention).
  task automatic test_wrap();
    set_req(0, 5'd1, 32'h0000_00A0, 1'b0, 1'b0);
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got %b want 0001", req_ready); end
    cyc();
    checks++; if (cdb_src !== 2'd0 || cdb_data !== 32'hA0) begin errors++; $display("FAIL wrap_bcast got s=%0d d=%h want 0 a0", cdb_src, cdb_data); end
    set_req(1, 5'd2, 32'h0000_00A1, 1'b0, 1'b0);
    req_valid = 4'b0011; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1 got %b want 0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_src !== 2'd1 || cdb_tag !== 5'd2) begin errors++; $display("FAIL wrap_bcast1 got s=%0d t=%0d want 1 2", cdb_src, cdb_tag); end
    cyc();
    checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd2 || cdb_data !== 32'hA1) begin errors++; $display("FAIL idle_hold got v=%b t=%0d d=%h want 0 2 a1", cdb_valid, cdb_tag, cdb_data); end
  endtask

  // rr_ptr 2 -> grant 1 -> pointer 2.
  task automatic test_branch();
    set_req(1, 5'd12, 32'h0000_0B0B, 1'b1, 1'b1);
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL branch_ready got %b want 0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 1'b1 || cdb_br !== 1'b1 || cdb_tk !== 1'b1 || cdb_tag !== 5'd12)
      begin errors++; $display("FAIL branch_bcast got v=%b b=%b k=%b t=%0d want 1 1 1 12", cdb_valid, cdb_br, cdb_tk, cdb_tag); end
  endtask

  // rr_ptr 2; flush with 0 and 3 valid, then grant resumes at 3 -> pointer 0.
  task automatic test_flush();
    set_req(0, 5'd20, 32'h0000_F000, 1'b0, 1'b0);
    set_req(3, 5'd23, 32'h0000_F003, 1'b0, 1'b0);
    req_valid = 4'b1001; flush = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", req_ready); end
    cyc();
    flush = 1'b0;
    checks++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd12) begin errors++; $display("FAIL flush_bcast got v=%b t=%0d want 0 12", cdb_valid, cdb_tag); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_resume got %b want 1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_tag !== 5'd23 || cdb_br !== 1'b0)
      begin errors++; $display("FAIL flush_resume_bcast got v=%b s=%0d t=%0d b=%b want 1 3 23 0", cdb_valid, cdb_src, cdb_tag, cdb_br); end
  endtask

  // rr_ptr 0, all valid: 0,1,2,3,0 -> pointer 1; then lone 3 -> pointer 0.
  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 32'(32'h100 + i), 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_gnt = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_gnt); end
      cyc();
      checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(k % 4) || cdb_tag !== 5'(10 + k % 4))
        begin errors++; $display("FAIL rr_bcast[%0d] got v=%b s=%0d t=%0d want 1 %0d %0d", k, cdb_valid, cdb_src, cdb_tag, k % 4, 10 + k % 4); end
    end
    req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_lone3 got %b want 1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
  endtask

  // rr_ptr 0. Requester 3 waits two cycles; in the third the override
  // (limit 2) picks 3 where round-robin alone would pick 2.
  task automatic test_starve();
    logic [3:0] exp_gnt;
    for (int i = 0; i < 4; i++) set_req(i, 5'(16 + i), 32'(32'h200 + i), 1'b0, 1'b0);
    req_valid = 4'b1011; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL starve_c0 got %b want 0001", req_ready); end
    cyc();
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL starve_c1 got %b want 0010", req_ready); end
    cyc();
`ifdef CDB_ARB_STARVE_EN
    exp_gnt = 4'b1000;
`else
    exp_gnt = 4'b0100;
`endif
    #1;
    checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL starve_c2 got %b want %b", req_ready, exp_gnt); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_tag !== ((exp_gnt == 4'b1000) ? 5'd19 : 5'd18)) begin errors++; $display("FAIL starve_bcast got t=%0d", cdb_tag); end
  endtask

  task automatic test_back_to_back();
    set_req(2, 5'd5, 32'hCAFE_0001, 1'b0, 1'b0);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready0 got %b want 0100", req_ready); end
    cyc();
    set_req(2, 5'd6, 32'hCAFE_0002, 1'b1, 1'b0); #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready1 got %b want 0100", req_ready); end
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_bcast0 got v=%b d=%h want 1 cafe0001", cdb_valid, cdb_data); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'hCAFE_0002 || cdb_tag !== 5'd6 || cdb_br !== 1'b1 || cdb_tk !== 1'b0)
      begin errors++; $display("FAIL b2b_bcast1 got v=%b d=%h t=%0d b=%b k=%b want 1 cafe0002 6 1 0", cdb_valid, cdb_data, cdb_tag, cdb_br, cdb_tk); end
    cyc();
    checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'hCAFE_0002) begin errors++; $display("FAIL b2b_idle got v=%b d=%h want 0 cafe0002", cdb_valid, cdb_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_branch();
    test_flush();
    test_round_robin();
    test_starve();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
